// File: rtl/tail_light_monitor.sv
// Decodes the tail-light lamp stream into idle/left/right/hazard, checks every step, counts cycles and errors.
// Latency 1 clk from a qualified sample; no backpressure, nothing changes on edges with sample_en low except pulses clearing.
module tail_light_monitor #(
    parameter int ERR_W  = 8,
    parameter int DONE_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sample_en,
    input  logic [2:0]        Lcba,
    input  logic [2:0]        Rabc,
    output logic [1:0]        mode,
    output logic              in_sync,
    output logic              err,
    output logic              abort,
    output logic              done,
    output logic [ERR_W-1:0]  err_count,
    output logic [DONE_W-1:0] done_count,
    output logic [3:0]        state_code
);

    typedef enum logic [3:0] {
        S_SYNC = 4'd0,
        S_IDLE = 4'd1,
        S_L1   = 4'd2,
        S_L2   = 4'd3,
        S_L3   = 4'd4,
        S_R1   = 4'd5,
        S_R2   = 4'd6,
        S_R3   = 4'd7,
        S_HAZ  = 4'd8
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic               in_sync_q, in_sync_d;
    logic               err_q, err_d;
    logic               abort_q, abort_d;
    logic               done_q, done_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
    logic [DONE_W-1:0]  done_cnt_q, done_cnt_d;

    logic [5:0] pat;
    logic       pat_idle;
    logic       illegal;

    assign pat      = {Lcba, Rabc};
    assign pat_idle = (pat == 6'b000_000);

    always_comb begin
        state_d    = state_q;
        err_d      = 1'b0;
        abort_d    = 1'b0;
        done_d     = 1'b0;
        err_cnt_d  = err_cnt_q;
        done_cnt_d = done_cnt_q;
        illegal    = 1'b0;

        if (sample_en) begin
            case (state_q)
                S_SYNC: if (pat_idle) state_d = S_IDLE;
                S_IDLE: begin
                    if (pat_idle)                 state_d = S_IDLE;
                    else if (pat == 6'b001_000)   state_d = S_L1;
                    else if (pat == 6'b000_100)   state_d = S_R1;
                    else if (pat == 6'b111_111)   state_d = S_HAZ;
                    else                          illegal = 1'b1;
                end
                S_L1: begin
                    if (pat == 6'b011_000)        state_d = S_L2;
                    else if (pat_idle)            abort_d = 1'b1;
                    else                          illegal = 1'b1;
                end
                S_L2: begin
                    if (pat == 6'b111_000)        state_d = S_L3;
                    else if (pat_idle)            abort_d = 1'b1;
                    else                          illegal = 1'b1;
                end
                S_R1: begin
                    if (pat == 6'b000_110)        state_d = S_R2;
                    else if (pat_idle)            abort_d = 1'b1;
                    else                          illegal = 1'b1;
                end
                S_R2: begin
                    if (pat == 6'b000_111)        state_d = S_R3;
                    else if (pat_idle)            abort_d = 1'b1;
                    else                          illegal = 1'b1;
                end
                S_L3, S_R3, S_HAZ: begin
                    if (pat_idle)                 done_d  = 1'b1;
                    else                          illegal = 1'b1;
                end
                default:                          illegal = 1'b1;
            endcase

            // Abort and completion both land in IDLE; illegal always drops lock.
            if (abort_d || done_d) state_d = S_IDLE;
            if (illegal) begin
                state_d = S_SYNC;
                err_d   = 1'b1;
                if (err_cnt_q != {ERR_W{1'b1}}) err_cnt_d = err_cnt_q + 1'b1;
            end
            if (done_d) done_cnt_d = done_cnt_q + 1'b1;
        end

        case (state_d)
            S_L1, S_L2, S_L3: mode_d = 2'b01;
            S_R1, S_R2, S_R3: mode_d = 2'b10;
            S_HAZ:            mode_d = 2'b11;
            default:          mode_d = 2'b00;
        endcase
        in_sync_d = (state_d != S_SYNC);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_SYNC;
            mode_q     <= 2'b00;
            in_sync_q  <= 1'b0;
            err_q      <= 1'b0;
            abort_q    <= 1'b0;
            done_q     <= 1'b0;
            err_cnt_q  <= '0;
            done_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            in_sync_q  <= in_sync_d;
            err_q      <= err_d;
            abort_q    <= abort_d;
            done_q     <= done_d;
            err_cnt_q  <= err_cnt_d;
            done_cnt_q <= done_cnt_d;
        end
    end

    assign mode       = mode_q;
    assign in_sync    = in_sync_q;
    assign err        = err_q;
    assign abort      = abort_q;
    assign done       = done_q;
    assign err_count  = err_cnt_q;
    assign done_count = done_cnt_q;
    assign state_code = state_q;

endmodule
